// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store front end for main_mem. It produces
//               word-addressed accesses and extends load data. It raises
//               misalignment exceptions and sequences FENCE.I.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ADDR_W = 14
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    input  logic              i_req_store,
    input  logic              i_req_fence_i,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_exc_misaligned,
    output logic [31:0]       o_exc_addr,
    output logic              o_dm_ren,
    output logic              o_dm_wen,
    output logic [3:0]        o_dm_ben,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [31:0]       o_dm_wdata,
    input  logic [31:0]       i_dm_rdata,
    output logic              o_fence_i,
    input  logic              i_mem_ready
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_RESP        = 2'd1;
    localparam logic [1:0] S_FENCE_HOLD  = 2'd2;
    localparam logic [1:0] S_FENCE_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_load;
    logic [31:0] r_exc_addr;

    logic        w_accept;
    logic        w_fence_acc;
    logic        w_ls_acc;
    logic        w_bad_f3;
    logic        w_mis;
    logic        w_go;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_unused_addr;

    assign w_unused_addr = ^i_addr[31:ADDR_W+2];

    assign w_accept    = i_req_valid && o_req_ready;
    assign w_fence_acc = w_accept && i_req_fence_i;
    assign w_ls_acc    = w_accept && !i_req_fence_i;

    // funct3[1:0] carries the access size; 011/110/111 have no RV32I meaning
    assign w_bad_f3 = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
    assign w_mis    = w_bad_f3
                   || ((i_funct3[1:0] == 2'b01) && i_addr[0])
                   || ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign w_go     = w_ls_acc && !w_mis;

    assign o_exc_misaligned = w_ls_acc && w_mis;
    assign o_exc_addr       = r_exc_addr;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_fence_acc) begin
                    w_next = S_FENCE_HOLD;
                end else if (w_go) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            // main_mem only drops ready one cycle after the fence pulse
            S_FENCE_HOLD:  w_next = S_FENCE_DRAIN;
            S_FENCE_DRAIN: w_next = i_mem_ready ? S_IDLE : S_FENCE_DRAIN;
            default:       w_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_fence_i    = 1'b0;
        if (!i_rst) begin
            o_req_ready  = ((r_state == S_IDLE) || (r_state == S_RESP)) && i_mem_ready;
            o_resp_valid = (r_state == S_RESP)
                        || ((r_state == S_FENCE_DRAIN) && i_mem_ready);
            o_fence_i    = i_req_valid && i_req_fence_i && o_req_ready;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_load     <= 1'b0;
            r_exc_addr <= 32'h0;
        end else begin
            if (w_go) begin
                r_funct3 <= i_funct3;
                r_off    <= i_addr[1:0];
                r_load   <= !i_req_store;
            end
            if (o_exc_misaligned) begin
                r_exc_addr <= i_addr;
            end
        end
    end

    always_comb begin
        o_dm_ren   = w_go && !i_req_store;
        o_dm_wen   = w_go && i_req_store;
        o_dm_addr  = w_go ? i_addr[ADDR_W+1:2] : '0;
        o_dm_ben   = 4'b0000;
        o_dm_wdata = 32'h0;
        if (w_go && i_req_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    o_dm_ben   = 4'b0001 << i_addr[1:0];
                    o_dm_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    o_dm_ben   = i_addr[1] ? 4'b1100 : 4'b0011;
                    o_dm_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_dm_ben   = 4'b1111;
                    o_dm_wdata = i_wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = i_dm_rdata[7:0];
            2'd1:    w_byte = i_dm_rdata[15:8];
            2'd2:    w_byte = i_dm_rdata[23:16];
            default: w_byte = i_dm_rdata[31:24];
        endcase
        w_half = r_off[1] ? i_dm_rdata[31:16] : i_dm_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b101:  w_ext = {16'h0, w_half};
            default: w_ext = i_dm_rdata;
        endcase
        o_resp_rdata = (!i_rst && (r_state == S_RESP) && r_load) ? w_ext : 32'h0;
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed bench for load_store_unit with a reference model
//               checked every cycle, plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, valid, store, fence, mem_ready;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, dm_rdata;
    logic        req_ready, resp_valid, exc, dm_ren, dm_wen, fence_i;
    logic [31:0] resp_rdata, exc_addr, dm_wdata;
    logic [3:0]  dm_ben;
    logic [13:0] dm_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(14)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_store(store),
        .i_req_fence_i(fence), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
        .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
        .o_exc_misaligned(exc), .o_exc_addr(exc_addr), .o_dm_ren(dm_ren),
        .o_dm_wen(dm_wen), .o_dm_ben(dm_ben), .o_dm_addr(dm_addr),
        .o_dm_wdata(dm_wdata), .i_dm_rdata(dm_rdata), .o_fence_i(fence_i),
        .i_mem_ready(mem_ready)
    );

    // Synchronous-read memory behind the port
    always @(posedge clk) begin
        if (dm_ren) dm_rdata <= mem[dm_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] fn);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * off));
        h = 16'(w >> (16 * off[1]));
        case (fn)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Reference model: pending responses as a queue, fence as an age count
    logic [31:0] m_q[$];
    logic        m_fence = 1'b0;
    int          m_age   = 0;
    logic [31:0] m_exc   = 32'h0;
    logic        e_rdy, e_acc, e_fen, e_ls, e_mis, e_go, e_rv;
    logic [31:0] e_rd, e_wd;
    logic [3:0]  e_ben;

    always @(negedge clk) begin
        e_rdy = !rst && mem_ready && !m_fence;
        e_acc = valid && e_rdy;
        e_fen = e_acc && fence;
        e_ls  = e_acc && !fence;
        e_mis = (f3 == 3'd3) || (f3 >= 3'd6)
             || (f3[1:0] == 2'd1 && addr[0])
             || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
        e_go  = e_ls && !e_mis;
        e_rv  = !rst && (m_q.size() > 0 || (m_fence && m_age >= 2 && mem_ready));
        e_rd  = (!rst && m_q.size() > 0) ? m_q[0] : 32'h0;
        e_ben = 4'h0;
        e_wd  = 32'h0;
        if (e_go && store) begin
            case (f3[1:0])
                2'd0: begin e_ben = 4'b0001 << addr[1:0]; e_wd = {4{wdata[7:0]}}; end
                2'd1: begin e_ben = 4'b0011 << (2 * addr[1]); e_wd = {2{wdata[15:0]}}; end
                default: begin e_ben = 4'hF; e_wd = wdata; end
            endcase
        end
        chk("m_req_ready", {31'h0, req_ready}, {31'h0, e_rdy});
        chk("m_resp_valid", {31'h0, resp_valid}, {31'h0, e_rv});
        chk("m_resp_rdata", resp_rdata, e_rd);
        chk("m_exc", {31'h0, exc}, {31'h0, e_ls && e_mis});
        chk("m_exc_addr", exc_addr, m_exc);
        chk("m_fence_i", {31'h0, fence_i}, {31'h0, e_fen});
        chk("m_ren", {31'h0, dm_ren}, {31'h0, e_go && !store});
        chk("m_wen", {31'h0, dm_wen}, {31'h0, e_go && store});
        chk("m_ben", {28'h0, dm_ben}, {28'h0, e_ben});
        chk("m_addr", {18'h0, dm_addr}, e_go ? {18'h0, addr[15:2]} : 32'h0);
        chk("m_wdata", dm_wdata, e_wd);
        if (rst) begin
            m_q.delete();
            m_fence = 1'b0;
            m_exc   = 32'h0;
        end else begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (m_fence) begin
                if (m_age >= 2 && mem_ready) m_fence = 1'b0;
                else m_age++;
            end
            if (e_fen) begin
                m_fence = 1'b1;
                m_age   = 1;
            end
            if (e_go) m_q.push_back(store ? 32'h0 : load_val(mem[addr[9:2]], addr[1:0], f3));
            if (e_ls && e_mis) m_exc = addr;
        end
    end

    task automatic set_req(input logic v, input logic s, input logic f, input logic [2:0] fn,
                           input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        valid = v; store = s; fence = f; f3 = fn; addr = a; wdata = d;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {i[7:0], ~i[7:0], 8'hA5, i[7:0] ^ 8'h3C};
        mem[8'h41] = 32'h8899AABB;
        rst = 1'b1; valid = 1'b0; store = 1'b0; fence = 1'b0; mem_ready = 1'b1;
        f3 = 3'd0; addr = 32'h0; wdata = 32'h0; dm_rdata = 32'h0;

        repeat (2) @(posedge clk);
        mid();
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_exc_addr", exc_addr, 32'h0);
        chk("rst_dm_wen", {31'h0, dm_wen}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        set_req(1, 0, 0, 3'b010, 32'h104, 0);
        mid();
        chk("lw_addr", {18'h0, dm_addr}, 32'h041);
        chk("lw_ren", {31'h0, dm_ren}, 32'h1);
        set_req(1, 0, 0, 3'b000, 32'h107, 0);
        mid();
        chk("lw_valid", {31'h0, resp_valid}, 32'h1);
        chk("lw_rdata", resp_rdata, 32'h8899AABB);
        set_req(1, 0, 0, 3'b100, 32'h107, 0);
        mid();
        chk("lb_rdata", resp_rdata, 32'hFFFFFF88);
        set_req(1, 0, 0, 3'b001, 32'h106, 0);
        mid();
        chk("lbu_rdata", resp_rdata, 32'h00000088);
        set_req(1, 0, 0, 3'b101, 32'h106, 0);
        mid();
        chk("lh_rdata", resp_rdata, 32'hFFFF8899);
        set_req(1, 1, 0, 3'b000, 32'h203, 32'h12345678);
        mid();
        chk("lhu_rdata", resp_rdata, 32'h00008899);
        chk("sb_ben", {28'h0, dm_ben}, 32'h8);
        chk("sb_wdata", dm_wdata, 32'h78787878);
        chk("sb_addr", {18'h0, dm_addr}, 32'h080);
        set_req(1, 1, 0, 3'b001, 32'h202, 32'h12345678);
        mid();
        chk("sh_ben", {28'h0, dm_ben}, 32'hC);
        chk("sh_wdata", dm_wdata, 32'h56785678);

        set_req(1, 0, 0, 3'b010, 32'h102, 0);
        mid();
        chk("lw_mis_exc", {31'h0, exc}, 32'h1);
        chk("lw_mis_ren", {31'h0, dm_ren}, 32'h0);
        set_req(1, 1, 0, 3'b001, 32'h001, 32'hFFFF);
        mid();
        chk("lw_mis_addr", exc_addr, 32'h102);
        chk("lw_mis_noresp", {31'h0, resp_valid}, 32'h0);
        chk("sh_mis_exc", {31'h0, exc}, 32'h1);
        chk("sh_mis_wen", {31'h0, dm_wen}, 32'h0);
        set_req(0, 0, 0, 0, 0, 0);
        mid();
        chk("sh_mis_addr", exc_addr, 32'h001);

        // Fence with a competing store; the store must wait for completion
        set_req(1, 1, 1, 3'b010, 32'h300, 32'hCAFEF00D);
        mid();
        chk("fence_pulse", {31'h0, fence_i}, 32'h1);
        chk("fence_beats_store", {31'h0, dm_wen}, 32'h0);
        set_req(1, 1, 0, 3'b010, 32'h300, 32'hCAFEF00D);
        mid();
        chk("fence_hold_pulse", {31'h0, fence_i}, 32'h0);
        chk("fence_hold_ready", {31'h0, req_ready}, 32'h0);
        chk("fence_hold_resp", {31'h0, resp_valid}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 mem_ready = 1'b0;
            mid();
            chk("fence_drain_resp", {31'h0, resp_valid}, 32'h0);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        mid();
        chk("fence_done_resp", {31'h0, resp_valid}, 32'h1);
        chk("fence_done_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        mid();
        chk("post_fence_store", {31'h0, dm_wen}, 32'h1);

        // Store pending while memory is not ready
        set_req(1, 1, 0, 3'b010, 32'h304, 32'h0BADBEEF);
        mem_ready = 1'b0;
        mid();
        chk("resp_despite_notready", {31'h0, resp_valid}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) mid();
            chk("notready_wen", {31'h0, dm_wen}, 32'h0);
            chk("notready_ready", {31'h0, req_ready}, 32'h0);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        mid();
        chk("ready_back_wen", {31'h0, dm_wen}, 32'h1);

        // Back-to-back LW, LW, SW
        set_req(1, 0, 0, 3'b010, 32'h104, 0);
        mid();
        chk("b2b_ready0", {31'h0, req_ready && dm_ren}, 32'h1);
        set_req(1, 0, 0, 3'b010, 32'h108, 0);
        mid();
        chk("b2b_ready1", {31'h0, req_ready && dm_ren}, 32'h1);
        set_req(1, 1, 0, 3'b010, 32'h10C, 32'h55AA55AA);
        mid();
        chk("b2b_ready2", {31'h0, req_ready && dm_wen}, 32'h1);

        // Reset during RESP discards the response
        set_req(1, 0, 0, 3'b010, 32'h104, 0);
        set_req(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        mid();
        chk("rst_in_resp", {31'h0, resp_valid}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        mid();
        chk("after_rst_resp", {31'h0, resp_valid}, 32'h0);

        set_req(1, 0, 0, 3'b011, 32'h100, 0);
        mid();
        chk("bad_f3_exc", {31'h0, exc}, 32'h1);
        set_req(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
